uart_tx: RTL
============

Name: uart_tx

Overview:
- Bus-mapped serial output peripheral; the CPU's path for sending data (e.g. encoded JPEG bytes) off-chip.
- The CPU writes bytes to a fixed bus address.
- Bytes queue in a small FIFO and are shifted out on tx as 8N1 UART frames.
- A status word is continuously driven on busdata so software can poll for full/busy.

Parameters:
- CLKRATE, 25000000, system clock frequency in Hz.
- BAUD, 115200, line rate in bit/s. BAUDDIV = CLKRATE / BAUD, integer division truncated; BAUDDIV >= 2 required.
- DEPTH, 4, FIFO depth in bytes; must be a power of 2, >= 2.

Ports:
- clk  input  1  system clock.
- nrst  input  1  reset, asynchronous, active-low.
- busaddr  input  32  CPU bus address.
- buswdata  input  32  CPU bus write data; only [7:0] used.
- buswrite  input  1  bus write strobe, 1 cycle per write.
- busdata  output  32  status word.
- tx  output  1  serial line; idle high.

Behaviour:
- Reset (async, nrst low):
  - tx = 1, busdata = 0.
  - FIFO empty (count = 0, pointers 0), FSM = IDLE, baud counter = 0, bit index = 0.
  - Reset mid-frame aborts the frame immediately and discards all queued bytes.
- Push:
  - Condition: buswrite = 1 and busaddr == 411710 (decimal) at a rising edge.
  - Stores buswdata[7:0] at the write pointer; count + 1.
  - If count == DEPTH (full, registered value) the write is silently dropped; no state change.
  - Writes to any other address are ignored.
- Status:
  - busdata = {16'b0, count[7:0], 6'b0, busy, full}, registered, updated every cycle, independent of busaddr.
  - full = (count == DEPTH).
  - busy = (FSM != IDLE) or (count != 0).
- FSM states: IDLE, START, DATA, STOP.
- IDLE: tx = 1. If count != 0 at an edge: pop the head byte into an 8-bit shift register, count - 1, baud counter = 0, go to START.
- START: tx = 0 for BAUDDIV cycles, then go to DATA with bit index 0.
- DATA:
  - tx = shift[0], each bit held BAUDDIV cycles, LSB first.
  - Shift right after each bit.
  - After bit index 7 completes, go to STOP.
- STOP: tx = 1 for BAUDDIV cycles. At the end:
  - if count != 0, pop the next byte and go directly to START, with no extra idle cycle;
  - else go to IDLE.
- Baud counter: counts 0..BAUDDIV-1, wraps to 0 at each bit boundary; cleared on entry to START.
- Frame length: exactly 10*BAUDDIV cycles.
- tx is registered, glitch-free, and driven from the FSM/shift-register state only.
- Latency: a push accepted at edge E0 with FIFO empty and FSM in IDLE produces the pop at E1. tx falls after E1 and stays low for BAUDDIV cycles.
- Simultaneous push and pop in the same cycle:
  - count unchanged;
  - the pushed byte is accepted unless the registered count == DEPTH, in which case it is dropped (full is not relieved same-cycle);
  - push and pop pointers advance independently and wrap modulo DEPTH.
- FIFO order is strictly first-in first-out; no data reordering across pointer wrap-around.

Test Plan:
- Single byte, CLKRATE=1000000, BAUD=100000 (BAUDDIV=10): write 0xA5 to 411710 → tx levels 0,1,0,1,0,0,1,0,1,1, each held 10 cycles. Start begins the cycle after the push edge. busy=1 for the whole frame; busy=0 after stop.
- Back-to-back and overflow: 5 consecutive writes 0x01,0x02,0x03,0x04,0x05 with DEPTH=4 and tx idle.
  - First byte is popped 1 cycle after its push, so pushes 2–5 fit.
  - Then a 6th write (0x06) while full: busdata[0]=1, the write is dropped.
  - Serial output is 0x01..0x05 contiguous, 50 cycles/frame, no idle gaps.
  - count is read back correctly in busdata[15:8].
- Address decode: buswrite with busaddr=411700 and 411714, data 0xFF → no FIFO change, tx stays 1, busdata stays 0.
- Wrap-around: push/drain 10 bytes 0x10..0x19 in interleaved groups of 3 → output order preserved across pointer wrap.
- Simultaneous push/pop: push exactly at the STOP-end edge with count=1 → next frame starts immediately, count stays 1, the new byte follows.
- Reset mid-frame: assert nrst during DATA bit 3 of 0x3C with 2 bytes queued → tx=1 and busdata=0 immediately. After release no further frames are sent until a new write.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: bus-mapped 8N1 serial transmitter with a small byte FIFO.
// The CPU writes bytes to PUSH_ADDR and polls busdata = {count, busy, full}.
module uart_tx #(
  parameter int CLKRATE = 25000000,
  parameter int BAUD    = 115200,
  parameter int DEPTH   = 4
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] busaddr,
  input  logic [31:0] buswdata,
  input  logic        buswrite,
  output logic [31:0] busdata,
  output logic        tx
);

  localparam int BAUDDIV = CLKRATE / BAUD;
  localparam int BW      = $clog2(BAUDDIV);
  localparam int AW      = $clog2(DEPTH);
  localparam int CW      = AW + 1;

  localparam logic [31:0]   PUSH_ADDR = 32'd411710;
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUDDIV - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_next;
  logic [BW-1:0] baud_cnt, baud_next;
  logic [2:0]    bit_idx, bit_next;
  logic [7:0]    shift, shift_next;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_next;
  logic          push, pop, bit_end;
  logic          tx_next, busy_next, full_next;
  logic [7:0]    count8_next;
  logic          wdata_unused;

  // buswrite is a one-cycle strobe with no back-pressure: a write while the
  // registered count is full is dropped, so software polls busdata[0] first.
  assign push    = buswrite && (busaddr == PUSH_ADDR) && (count != FULL_CNT);
  assign bit_end = (baud_cnt == BAUD_LAST);
  assign wdata_unused = ^buswdata[31:8];

  always_comb begin
    state_next = state;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    shift_next = shift;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr];
          baud_next  = '0;
          state_next = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_next  = '0;
          bit_next   = 3'd0;
          state_next = DATA;
        end else begin
          baud_next = baud_cnt + BW'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_next  = '0;
          shift_next = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) begin
            state_next = STOP;
          end else begin
            bit_next = bit_idx + 3'd1;
          end
        end else begin
          baud_next = baud_cnt + BW'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_next = '0;
          // Chain straight into the next start bit so queued bytes go out gap-free.
          if (count != '0) begin
            pop        = 1'b1;
            shift_next = mem[rd_ptr];
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_cnt + BW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    count_next = count;
    if (push && !pop) begin
      count_next = count + CW'(1);
    end else if (!push && pop) begin
      count_next = count - CW'(1);
    end
  end

  // tx and status are registered from next-state values so they change only at clock edges.
  always_comb begin
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      default: tx_next = 1'b1;
    endcase
    busy_next   = (state_next != IDLE) || (count_next != '0);
    full_next   = (count_next == FULL_CNT);
    count8_next = 8'(count_next);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      tx       <= 1'b1;
      busdata  <= '0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_idx  <= bit_next;
      shift    <= shift_next;
      count    <= count_next;
      tx       <= tx_next;
      busdata  <= {16'h0, count8_next, 6'h0, busy_next, full_next};
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= buswdata[7:0];
    end
  end

endmodule
